// File: rtl/phy_tx_scheduler.sv
// phy_tx_scheduler: fixed-priority transmit arbiter for phy_tx_packet_editor with inter-frame gap and rx-busy discard.
// Optional BIST carrier support is built when PHY_TX_SCHED_BIST_EN is defined.
module phy_tx_scheduler #(
    parameter int IFG_CYCLES = 8,
    parameter int IFG_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_hardreset_req,
    output logic       tx_hardreset_done,
    input  logic       tx_cablereset_req,
    output logic       tx_cablereset_done,
    input  logic       tx_goodcrc_req,
    input  logic [1:0] tx_goodcrc_sop,
    output logic       tx_goodcrc_done,
    input  logic       tx_msg_req,
    input  logic [1:0] tx_msg_sop,
    output logic       tx_msg_done,
    output logic       tx_msg_discard,
    input  logic       tx_bist_req,
    output logic       tx_bist_active,
    input  logic       rx_busy,
    input  logic       phy_bmc_encoder_data_done,
    input  logic       phy_bmc_encoder_hold_lowbmc_done,
    output logic       phy_tx_packet_en,
    output logic [2:0] phy_tx_packet_type,
    output logic       phy_tx_bist_en,
    output logic [1:0] phy_tx_src,
    output logic       tx_busy
);
`ifdef PHY_TX_SCHED_BIST_EN
    typedef enum logic [1:0] {IDLE, SEND, BIST, BIST_DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
    logic unused_bist;
    assign unused_bist = tx_bist_req ^ phy_bmc_encoder_data_done;
`endif

    state_t state, state_nx;
    logic hr_p, cr_p, gc_p, msg_p;
    logic hr_nx, cr_nx, gc_nx, msg_nx;
    logic [1:0] gc_sop, msg_sop, gc_sop_nx, msg_sop_nx;
    logic [IFG_W-1:0] gap, gap_nx;
    logic en_nx, bist_en_nx, bist_act_nx;
    logic [2:0] type_nx;
    logic [1:0] src_nx;
    logic hr_done_nx, cr_done_nx, gc_done_nx, msg_done_nx, msg_disc_nx;

    // Requests arriving on an arbitration edge compete alongside already-pending flags.
    logic hr_e, cr_e, gc_e, msg_e;
    logic [1:0] gc_sop_e, msg_sop_e;
    assign hr_e      = hr_p | tx_hardreset_req;
    assign cr_e      = cr_p | tx_cablereset_req;
    assign gc_e      = gc_p | tx_goodcrc_req;
    assign msg_e     = msg_p | tx_msg_req;
    assign gc_sop_e  = gc_p ? gc_sop : tx_goodcrc_sop;
    assign msg_sop_e = msg_p ? msg_sop : tx_msg_sop;

    // The packet in flight is identified from the registered type/src pair.
    logic cur_hr, cur_cr, cur_gc, cur_msg;
    assign cur_hr  = phy_tx_src == 2'd0 && phy_tx_packet_type == 3'd3;
    assign cur_cr  = phy_tx_src == 2'd0 && phy_tx_packet_type == 3'd4;
    assign cur_gc  = phy_tx_src == 2'd1;
    assign cur_msg = phy_tx_src == 2'd2;

    assign tx_busy = state != IDLE || gap != '0;

    always_comb begin
        state_nx    = state;
        hr_nx       = hr_e;
        cr_nx       = cr_e;
        gc_nx       = gc_e;
        msg_nx      = msg_e;
        gc_sop_nx   = gc_sop_e;
        msg_sop_nx  = msg_sop_e;
        gap_nx      = (state == IDLE && gap != '0) ? gap - IFG_W'(1) : gap;
        en_nx       = phy_tx_packet_en;
        type_nx     = phy_tx_packet_type;
        src_nx      = phy_tx_src;
        bist_en_nx  = 1'b0;
        bist_act_nx = 1'b0;
        hr_done_nx  = 1'b0;
        cr_done_nx  = 1'b0;
        gc_done_nx  = 1'b0;
        msg_done_nx = 1'b0;
        msg_disc_nx = 1'b0;
        case (state)
            IDLE: if (gap == '0) begin
                if (hr_e || cr_e) begin
                    state_nx    = SEND;
                    en_nx       = 1'b1;
                    type_nx     = hr_e ? 3'd3 : 3'd4;
                    src_nx      = 2'd0;
                    msg_disc_nx = msg_e;
                    msg_nx      = 1'b0;
                end else if (gc_e) begin
                    // A GoodCRC blocked by rx_busy holds the bus; lower sources wait behind it.
                    if (!rx_busy) begin
                        state_nx = SEND;
                        en_nx    = 1'b1;
                        type_nx  = {1'b0, gc_sop_e};
                        src_nx   = 2'd1;
                    end
                end else if (msg_e) begin
                    if (rx_busy) begin
                        msg_disc_nx = 1'b1;
                        msg_nx      = 1'b0;
                    end else begin
                        state_nx = SEND;
                        en_nx    = 1'b1;
                        type_nx  = {1'b0, msg_sop_e};
                        src_nx   = 2'd2;
                    end
                end
`ifdef PHY_TX_SCHED_BIST_EN
                else if (tx_bist_req) begin
                    state_nx    = BIST;
                    bist_en_nx  = 1'b1;
                    bist_act_nx = 1'b1;
                end
`endif
            end
            SEND: if (phy_bmc_encoder_hold_lowbmc_done) begin
                state_nx    = IDLE;
                en_nx       = 1'b0;
                type_nx     = 3'd0;
                src_nx      = 2'd0;
                gap_nx      = IFG_W'(IFG_CYCLES);
                hr_done_nx  = cur_hr;
                cr_done_nx  = cur_cr;
                gc_done_nx  = cur_gc;
                msg_done_nx = cur_msg;
                hr_nx       = hr_e & ~cur_hr;
                cr_nx       = cr_e & ~cur_cr;
                gc_nx       = gc_e & ~cur_gc;
                msg_nx      = msg_e & ~cur_msg;
            end
`ifdef PHY_TX_SCHED_BIST_EN
            BIST: begin
                bist_act_nx = 1'b1;
                if (hr_e || cr_e || gc_e || msg_e || !tx_bist_req) state_nx = BIST_DRAIN;
                else bist_en_nx = 1'b1;
            end
            BIST_DRAIN: if (phy_bmc_encoder_data_done) begin
                state_nx = IDLE;
                gap_nx   = IFG_W'(IFG_CYCLES);
            end else begin
                bist_act_nx = 1'b1;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            hr_p               <= 1'b0;
            cr_p               <= 1'b0;
            gc_p               <= 1'b0;
            msg_p              <= 1'b0;
            gc_sop             <= 2'd0;
            msg_sop            <= 2'd0;
            gap                <= '0;
            phy_tx_packet_en   <= 1'b0;
            phy_tx_packet_type <= 3'd0;
            phy_tx_src         <= 2'd0;
            phy_tx_bist_en     <= 1'b0;
            tx_bist_active     <= 1'b0;
            tx_hardreset_done  <= 1'b0;
            tx_cablereset_done <= 1'b0;
            tx_goodcrc_done    <= 1'b0;
            tx_msg_done        <= 1'b0;
            tx_msg_discard     <= 1'b0;
        end else begin
            state              <= state_nx;
            hr_p               <= hr_nx;
            cr_p               <= cr_nx;
            gc_p               <= gc_nx;
            msg_p              <= msg_nx;
            gc_sop             <= gc_sop_nx;
            msg_sop            <= msg_sop_nx;
            gap                <= gap_nx;
            phy_tx_packet_en   <= en_nx;
            phy_tx_packet_type <= type_nx;
            phy_tx_src         <= src_nx;
            phy_tx_bist_en     <= bist_en_nx;
            tx_bist_active     <= bist_act_nx;
            tx_hardreset_done  <= hr_done_nx;
            tx_cablereset_done <= cr_done_nx;
            tx_goodcrc_done    <= gc_done_nx;
            tx_msg_done        <= msg_done_nx;
            tx_msg_discard     <= msg_disc_nx;
        end
    end
endmodule
